// File: rtl/pulse_swallow_div.sv
// Pulse-swallow programmable clock divider: N = M*P + S clk_in cycles per period.
// The first S prescaler cycles run at /(P+1), the rest at /P; config changes apply at period start.
module pulse_swallow_div #(
  parameter int unsigned P   = 4,
  parameter int unsigned M_W = 6,
  parameter int unsigned S_W = 3
) (
  input  logic           clk_in,
  input  logic           rst_b,
  input  logic           load,
  input  logic [M_W-1:0] m_val,
  input  logic [S_W-1:0] s_val,
  input  logic           duty_mode,
  output logic           clk_out,
  output logic           mod_ctl,
  output logic           cfg_err
);

  localparam int unsigned NMAX = ((1 << M_W) - 1) * P + ((1 << S_W) - 1);
  localparam int unsigned NW   = $clog2(NMAX + 1);
  localparam int unsigned PW   = $clog2(P + 1);
  localparam int unsigned CW   = (M_W > S_W) ? M_W : S_W;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t         state_q;
  logic [PW-1:0]  pre_q;
  logic [M_W-1:0] cyc_q;
  logic [NW-1:0]  t_q;
  logic [NW-1:0]  half_q;
  logic [M_W-1:0] m_act_q, m_pend_q;
  logic [S_W-1:0] s_act_q, s_pend_q;
  logic           duty_q;
  logic           clk_out_q, mod_ctl_q, cfg_err_q;

  logic           pre_last, period_last, boundary, cfg_valid;
  logic [M_W-1:0] cyc_d;
  logic [NW-1:0]  t_d;
  logic [NW-1:0]  n_pend, half_pend;

  always_comb begin
    // mod_ctl_q already describes the current prescaler cycle, so it selects the modulus.
    pre_last    = mod_ctl_q ? (pre_q == PW'(P)) : (pre_q == PW'(P - 1));
    period_last = pre_last && (cyc_q == m_act_q - M_W'(1));
    boundary    = (state_q == ST_IDLE) || period_last;
    cyc_d       = cyc_q + M_W'(1);
    t_d         = t_q + NW'(1);
    n_pend      = NW'(m_pend_q) * NW'(P) + NW'(s_pend_q);
    half_pend   = n_pend >> 1;
    cfg_valid   = (m_val != '0) && (CW'(s_val) <= CW'(m_val));
  end

  always_ff @(posedge clk_in or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= ST_IDLE;
      pre_q     <= '0;
      cyc_q     <= '0;
      t_q       <= '0;
      half_q    <= NW'(P / 2);
      m_act_q   <= M_W'(1);
      s_act_q   <= '0;
      m_pend_q  <= M_W'(1);
      s_pend_q  <= '0;
      duty_q    <= 1'b0;
      clk_out_q <= 1'b0;
      mod_ctl_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q <= ST_RUN;
      if (load) begin
        if (cfg_valid) begin
          m_pend_q  <= m_val;
          s_pend_q  <= s_val;
          cfg_err_q <= 1'b0;
        end else begin
          cfg_err_q <= 1'b1;
        end
      end
      if (boundary) begin
        m_act_q   <= m_pend_q;
        s_act_q   <= s_pend_q;
        half_q    <= half_pend;
        duty_q    <= duty_mode;
        pre_q     <= '0;
        cyc_q     <= '0;
        t_q       <= '0;
        clk_out_q <= 1'b1;
        mod_ctl_q <= (s_pend_q != '0);
      end else begin
        t_q       <= t_d;
        clk_out_q <= duty_q && (t_d < half_q);
        if (pre_last) begin
          pre_q     <= '0;
          cyc_q     <= cyc_d;
          mod_ctl_q <= CW'(cyc_d) < CW'(s_act_q);
        end else begin
          pre_q <= pre_q + PW'(1);
        end
      end
    end
  end

  assign clk_out = clk_out_q;
  assign mod_ctl = mod_ctl_q;
  assign cfg_err = cfg_err_q;

endmodule
